fu_agu: RTL and testbench

FU_AGU -- requirements
Module: fu_agu

---
 rtl/fu_agu_if.sv | 36 +++
 rtl/fu_agu.sv | 166 ++++++++++++++++
 tb/tb_fu_agu.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_agu_if.sv
// Issue-side request bus and result bus of the address generation unit.
// The issuing side uses master; the AGU itself uses slave.
interface fu_agu_if #(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 2,
    parameter int TAG_W  = 5
);
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH*XLEN-1:0]  in_op1;
    logic [NUM_CH*32-1:0]    in_inst;
    logic [NUM_CH-1:0]       in_rd;
    logic [NUM_CH-1:0]       in_wr;
    logic [NUM_CH*TAG_W-1:0] in_tag;

    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         out_addr;
    logic [XLEN/8-1:0]       out_be;
    logic                    out_wr;
    logic [1:0]              out_size;
    logic [TAG_W-1:0]        out_tag;
    logic                    out_misaligned;

    modport master (
        output in_valid, in_op1, in_inst, in_rd, in_wr, in_tag, out_ready,
        input  in_ready, out_valid, out_addr, out_be, out_wr, out_size,
               out_tag, out_misaligned
    );

    modport slave (
        input  in_valid, in_op1, in_inst, in_rd, in_wr, in_tag, out_ready,
        output in_ready, out_valid, out_addr, out_be, out_wr, out_size,
               out_tag, out_misaligned
    );
endinterface

// File: rtl/fu_agu.sv
// Two-stage load/store address generation unit with round-robin issue arbitration.
// Stage 1 forms base+immediate; stage 2 derives byte enables and the misalignment flag.
module fu_agu #(
    parameter int XLEN   = 32,
    parameter int NUM_CH = 2,
    parameter int TAG_W  = 5
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     flush,
    fu_agu_if.slave  bus
);
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr,
                                           input logic [1:0]      size);
        logic [2:0] mask;
        mask = 3'((4'd1 << size) - 4'd1);
        if (size == 2'd3 && XLEN == 32) return 1'b1;
        return (addr[2:0] & mask) != 3'd0;
    endfunction

    function automatic logic [BE_W-1:0] byte_en(input logic [OFF_W-1:0] off,
                                                input logic [1:0]       size);
        logic [8:0] span;
        span = (9'd1 << (4'd1 << size)) - 9'd1;
        return BE_W'(span) << off;
    endfunction

    logic [PTR_W-1:0]        rr_ptr;
    logic [PTR_W-1:0]        grant;
    logic [PTR_W-1:0]        next_ptr;
    logic                    found;
    logic [NUM_CH-1:0]       ready;
    logic                    xfer;
    logic                    adv_p1;
    logic                    open_p1;

    logic [XLEN-1:0]         op1_sel;
    logic [11:0]             inst_hi;
    logic [4:0]              inst_lo;
    logic [1:0]              size_sel;
    logic                    rd_sel;
    logic                    wr_sel;
    logic [TAG_W-1:0]        tag_sel;
    logic signed [11:0]      imm_sel;
    logic signed [XLEN-1:0]  imm_x;
    logic [XLEN-1:0]         addr_sum;

    logic                    vld_p1;
    logic [XLEN-1:0]         addr_p1;
    logic                    wr_p1;
    logic [1:0]              size_p1;
    logic [TAG_W-1:0]        tag_p1;
    logic                    mis_p1;
    logic [BE_W-1:0]         be_p1;

    logic                    vld_p2;
    logic [XLEN-1:0]         addr_p2;
    logic [BE_W-1:0]         be_p2;
    logic                    wr_p2;
    logic [1:0]              size_p2;
    logic [TAG_W-1:0]        tag_p2;
    logic                    mis_p2;

    // First valid channel at or after rr_ptr, wrapping
    always_comb begin
        int idx;
        grant = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!found && bus.in_valid[idx]) begin
                grant = PTR_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign adv_p1   = !vld_p2 || bus.out_ready;
    assign open_p1  = !vld_p1 || adv_p1;
    assign next_ptr = PTR_W'((int'(grant) + 1) % NUM_CH);

    always_comb begin
        ready = '0;
        if (reset && !flush && open_p1) ready[grant] = 1'b1;
    end

    assign bus.in_ready = ready;
    assign xfer         = |(bus.in_valid & ready);

    assign op1_sel  = bus.in_op1[grant*XLEN +: XLEN];
    assign inst_hi  = bus.in_inst[grant*32 + 20 +: 12];
    assign inst_lo  = bus.in_inst[grant*32 + 7 +: 5];
    assign size_sel = bus.in_inst[grant*32 + 12 +: 2];
    assign rd_sel   = bus.in_rd[grant];
    assign wr_sel   = bus.in_wr[grant];
    assign tag_sel  = bus.in_tag[grant*TAG_W +: TAG_W];

    // Stores use the S-immediate, everything else the I-immediate
    assign imm_sel  = wr_sel ? {inst_hi[11:5], inst_lo} : inst_hi;
    assign imm_x    = imm_sel;
    assign addr_sum = op1_sel + imm_x;

    // Stage 0 -> 1: accept and form effective address; non-memory requests are dropped
    always_ff @(posedge clock) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            rr_ptr <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (xfer) begin
                vld_p1 <= rd_sel | wr_sel;
                rr_ptr <= next_ptr;
            end else if (adv_p1) begin
                vld_p1 <= 1'b0;
            end
            if (adv_p1) vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clock) begin
        if (xfer) begin
            addr_p1 <= addr_sum;
            wr_p1   <= wr_sel;
            size_p1 <= size_sel;
            tag_p1  <= tag_sel;
        end
    end

    assign mis_p1 = is_misaligned(addr_p1, size_p1);
    assign be_p1  = mis_p1 ? '0 : byte_en(addr_p1[OFF_W-1:0], size_p1);

    // Stage 1 -> 2: output register, held while the consumer stalls
    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_p2 <= '0;
            be_p2   <= '0;
            wr_p2   <= 1'b0;
            size_p2 <= 2'd0;
            tag_p2  <= '0;
            mis_p2  <= 1'b0;
        end else if (!flush && adv_p1 && vld_p1) begin
            addr_p2 <= addr_p1;
            be_p2   <= be_p1;
            wr_p2   <= wr_p1;
            size_p2 <= size_p1;
            tag_p2  <= tag_p1;
            mis_p2  <= mis_p1;
        end
    end

    assign bus.out_valid      = vld_p2;
    assign bus.out_addr       = addr_p2;
    assign bus.out_be         = be_p2;
    assign bus.out_wr         = wr_p2;
    assign bus.out_size       = size_p2;
    assign bus.out_tag        = tag_p2;
    assign bus.out_misaligned = mis_p2;
endmodule

// File: tb/tb_fu_agu.sv
// Directed bench for fu_agu: a 32-bit two-channel instance and a 64-bit instance.
module tb_fu_agu;
    localparam logic [31:0] LW = 32'hFFC0_2003;  // lw  x0, -4(x0)
    localparam logic [31:0] SH = 32'h0000_10A3;  // sh  x0, 1(x0)
    localparam logic [31:0] LD = 32'h0080_3003;  // ld  x0, 8(x0)

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fu_agu_if #(.XLEN(32), .NUM_CH(2), .TAG_W(5)) b32();
    fu_agu_if #(.XLEN(64), .NUM_CH(2), .TAG_W(5)) b64();

    fu_agu #(.XLEN(32), .NUM_CH(2), .TAG_W(5)) dut32 (
        .clock(clock), .reset(reset), .flush(flush), .bus(b32)
    );
    fu_agu #(.XLEN(64), .NUM_CH(2), .TAG_W(5)) dut64 (
        .clock(clock), .reset(reset), .flush(flush), .bus(b64)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        b32.in_valid = '0; b32.in_op1 = '0; b32.in_inst = '0;
        b32.in_rd = '0; b32.in_wr = '0; b32.in_tag = '0; b32.out_ready = 1'b1;
        b64.in_valid = '0; b64.in_op1 = '0; b64.in_inst = '0;
        b64.in_rd = '0; b64.in_wr = '0; b64.in_tag = '0; b64.out_ready = 1'b1;
    endtask

    task automatic put32(input int ch, input logic [31:0] op1, input logic [31:0] inst,
                         input logic rd, input logic wr, input logic [4:0] tag);
        b32.in_valid[ch]        = 1'b1;
        b32.in_op1[ch*32 +: 32] = op1;
        b32.in_inst[ch*32 +: 32] = inst;
        b32.in_rd[ch]           = rd;
        b32.in_wr[ch]           = wr;
        b32.in_tag[ch*5 +: 5]   = tag;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        b32.in_valid = 2'b11;
        step(); step();
        checks++; if (b32.in_ready !== 2'b00) begin errors++; $display("FAIL reset_in_ready: got %b exp 00", b32.in_ready); end
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", b32.out_valid); end
        checks++; if (b32.out_addr !== 32'h0) begin errors++; $display("FAIL reset_out_addr: got %h exp 0", b32.out_addr); end
        checks++; if (b32.out_be !== 4'h0) begin errors++; $display("FAIL reset_out_be: got %h exp 0", b32.out_be); end
        checks++; if ({b32.out_tag, b32.out_size, b32.out_wr, b32.out_misaligned} !== 9'h0) begin
            errors++; $display("FAIL reset_out_fields: got tag=%h size=%h wr=%b mis=%b exp all 0",
                               b32.out_tag, b32.out_size, b32.out_wr, b32.out_misaligned); end
        checks++; if (b64.out_valid !== 1'b0) begin errors++; $display("FAIL reset64_out_valid: got %b exp 0", b64.out_valid); end
        idle();
        reset = 1'b1;
    endtask

    task automatic test_load();
        put32(0, 32'h1000, LW, 1'b1, 1'b0, 5'd5);
        settle();
        checks++; if (b32.in_ready !== 2'b01) begin errors++; $display("FAIL load_ready: got %b exp 01", b32.in_ready); end
        step();
        b32.in_valid = '0;
        settle();
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL load_latency1: got %b exp 0", b32.out_valid); end
        step();
        checks++; if (b32.out_valid !== 1'b1) begin errors++; $display("FAIL load_valid: got %b exp 1", b32.out_valid); end
        checks++; if (b32.out_addr !== 32'h0FFC) begin errors++; $display("FAIL load_addr: got %h exp 00000ffc", b32.out_addr); end
        checks++; if (b32.out_be !== 4'hF) begin errors++; $display("FAIL load_be: got %h exp f", b32.out_be); end
        checks++; if ({b32.out_wr, b32.out_misaligned, b32.out_size, b32.out_tag} !== {1'b0, 1'b0, 2'd2, 5'd5}) begin
            errors++; $display("FAIL load_fields: got wr=%b mis=%b size=%0d tag=%0d exp wr=0 mis=0 size=2 tag=5",
                               b32.out_wr, b32.out_misaligned, b32.out_size, b32.out_tag); end
        step();
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL load_drain: got %b exp 0", b32.out_valid); end
        // Doubleword on a 32-bit AGU is always illegal
        put32(1, 32'h1000, LD, 1'b1, 1'b0, 5'd6);
        settle();
        checks++; if (b32.in_ready !== 2'b10) begin errors++; $display("FAIL ld32_ready: got %b exp 10", b32.in_ready); end
        step();
        b32.in_valid = '0;
        step();
        checks++; if ({b32.out_valid, b32.out_addr, b32.out_be, b32.out_misaligned, b32.out_size} !== {1'b1, 32'h1008, 4'h0, 1'b1, 2'd3}) begin
            errors++; $display("FAIL ld32_misaligned: got v=%b addr=%h be=%h mis=%b size=%0d exp v=1 addr=00001008 be=0 mis=1 size=3",
                               b32.out_valid, b32.out_addr, b32.out_be, b32.out_misaligned, b32.out_size); end
        step();
    endtask

    task automatic test_store();
        put32(1, 32'h2001, SH, 1'b0, 1'b1, 5'd9);
        settle();
        checks++; if (b32.in_ready !== 2'b10) begin errors++; $display("FAIL store_ready: got %b exp 10", b32.in_ready); end
        step();
        put32(1, 32'h2002, SH, 1'b0, 1'b1, 5'd10);
        step();
        b32.in_valid = '0;
        settle();
        checks++; if ({b32.out_valid, b32.out_addr, b32.out_be, b32.out_wr, b32.out_misaligned, b32.out_size, b32.out_tag} !==
                      {1'b1, 32'h2002, 4'hC, 1'b1, 1'b0, 2'd1, 5'd9}) begin
            errors++; $display("FAIL store_sh_aligned: got v=%b addr=%h be=%h wr=%b mis=%b size=%0d tag=%0d exp v=1 addr=00002002 be=c wr=1 mis=0 size=1 tag=9",
                               b32.out_valid, b32.out_addr, b32.out_be, b32.out_wr, b32.out_misaligned, b32.out_size, b32.out_tag); end
        step();
        checks++; if ({b32.out_valid, b32.out_addr, b32.out_be, b32.out_wr, b32.out_misaligned, b32.out_tag} !==
                      {1'b1, 32'h2003, 4'h0, 1'b1, 1'b1, 5'd10}) begin
            errors++; $display("FAIL store_sh_misaligned: got v=%b addr=%h be=%h wr=%b mis=%b tag=%0d exp v=1 addr=00002003 be=0 wr=1 mis=1 tag=10",
                               b32.out_valid, b32.out_addr, b32.out_be, b32.out_wr, b32.out_misaligned, b32.out_tag); end
        step();
        // rd and wr both set: treated as a store with the S-immediate
        put32(0, 32'h3001, SH, 1'b1, 1'b1, 5'd11);
        step();
        b32.in_valid = '0;
        step();
        checks++; if ({b32.out_valid, b32.out_addr, b32.out_be, b32.out_wr} !== {1'b1, 32'h3002, 4'hC, 1'b1}) begin
            errors++; $display("FAIL store_priority: got v=%b addr=%h be=%h wr=%b exp v=1 addr=00003002 be=c wr=1",
                               b32.out_valid, b32.out_addr, b32.out_be, b32.out_wr); end
        step();
    endtask

    task automatic test_discard();
        put32(0, 32'h100, LW, 1'b0, 1'b0, 5'd12);
        step();
        put32(0, 32'h100, LW, 1'b1, 1'b0, 5'd13);
        step();
        b32.in_valid = '0;
        settle();
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL discard_dropped: got %b exp 0", b32.out_valid); end
        step();
        checks++; if ({b32.out_valid, b32.out_tag, b32.out_addr} !== {1'b1, 5'd13, 32'hFC}) begin
            errors++; $display("FAIL discard_next: got v=%b tag=%0d addr=%h exp v=1 tag=13 addr=000000fc",
                               b32.out_valid, b32.out_tag, b32.out_addr); end
        step();
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL discard_drain: got %b exp 0", b32.out_valid); end
    endtask

    task automatic test_arbitration();
        logic [1:0]  exp_rdy;
        logic [4:0]  exp_tag;
        logic [31:0] exp_addr;
        reset = 1'b0;
        step();
        reset = 1'b1;
        put32(0, 32'h40, LW, 1'b1, 1'b0, 5'd3);
        put32(1, 32'h80, LW, 1'b1, 1'b0, 5'd7);
        settle();
        for (int i = 0; i < 8; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (b32.in_ready !== exp_rdy) begin
                errors++; $display("FAIL arb_grant[%0d]: got %b exp %b", i, b32.in_ready, exp_rdy); end
            if (i >= 2) begin
                exp_tag  = (i % 2 == 0) ? 5'd3 : 5'd7;
                exp_addr = (i % 2 == 0) ? 32'h3C : 32'h7C;
                checks++; if ({b32.out_valid, b32.out_tag, b32.out_addr} !== {1'b1, exp_tag, exp_addr}) begin
                    errors++; $display("FAIL arb_out[%0d]: got v=%b tag=%0d addr=%h exp v=1 tag=%0d addr=%h",
                                       i, b32.out_valid, b32.out_tag, b32.out_addr, exp_tag, exp_addr); end
            end
            step();
            settle();
        end
        idle();
        step(); step();
    endtask

    task automatic test_back_to_back();
        b32.out_ready = 1'b0;
        put32(0, 32'h10, LW, 1'b1, 1'b0, 5'd1);
        settle();
        checks++; if (b32.in_ready !== 2'b01) begin errors++; $display("FAIL bp_accept_a: got %b exp 01", b32.in_ready); end
        step();
        put32(0, 32'h20, LW, 1'b1, 1'b0, 5'd2);
        settle();
        checks++; if (b32.in_ready !== 2'b01) begin errors++; $display("FAIL bp_accept_b: got %b exp 01", b32.in_ready); end
        step();
        put32(0, 32'h30, LW, 1'b1, 1'b0, 5'd3);
        settle();
        for (int i = 0; i < 5; i++) begin
            checks++; if ({b32.in_ready, b32.out_valid, b32.out_tag, b32.out_addr, b32.out_be} !== {2'b00, 1'b1, 5'd1, 32'hC, 4'hF}) begin
                errors++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b tag=%0d addr=%h be=%h exp rdy=00 v=1 tag=1 addr=0000000c be=f",
                                   i, b32.in_ready, b32.out_valid, b32.out_tag, b32.out_addr, b32.out_be); end
            step();
        end
        b32.out_ready = 1'b1;
        settle();
        checks++; if ({b32.in_ready, b32.out_tag} !== {2'b01, 5'd1}) begin
            errors++; $display("FAIL bp_resume: got rdy=%b tag=%0d exp rdy=01 tag=1", b32.in_ready, b32.out_tag); end
        step();
        b32.in_valid = '0;
        checks++; if ({b32.out_valid, b32.out_tag, b32.out_addr} !== {1'b1, 5'd2, 32'h1C}) begin
            errors++; $display("FAIL bp_second: got v=%b tag=%0d addr=%h exp v=1 tag=2 addr=0000001c",
                               b32.out_valid, b32.out_tag, b32.out_addr); end
        step();
        checks++; if ({b32.out_valid, b32.out_tag, b32.out_addr} !== {1'b1, 5'd3, 32'h2C}) begin
            errors++; $display("FAIL bp_third: got v=%b tag=%0d addr=%h exp v=1 tag=3 addr=0000002c",
                               b32.out_valid, b32.out_tag, b32.out_addr); end
        step();
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b exp 0", b32.out_valid); end
    endtask

    task automatic test_flush();
        b32.out_ready = 1'b0;
        put32(1, 32'h50, LW, 1'b1, 1'b0, 5'd4);
        settle();
        checks++; if (b32.in_ready !== 2'b10) begin errors++; $display("FAIL flush_fill_a: got %b exp 10", b32.in_ready); end
        step();
        b32.in_valid = '0;
        put32(0, 32'h60, LW, 1'b1, 1'b0, 5'd5);
        settle();
        checks++; if (b32.in_ready !== 2'b01) begin errors++; $display("FAIL flush_fill_b: got %b exp 01", b32.in_ready); end
        step();
        put32(1, 32'h70, LW, 1'b1, 1'b0, 5'd6);
        flush = 1'b1;
        b32.out_ready = 1'b1;
        settle();
        checks++; if ({b32.in_ready, b32.out_valid, b32.out_tag} !== {2'b00, 1'b1, 5'd4}) begin
            errors++; $display("FAIL flush_active: got rdy=%b v=%b tag=%0d exp rdy=00 v=1 tag=4",
                               b32.in_ready, b32.out_valid, b32.out_tag); end
        step();
        flush = 1'b0;
        settle();
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b exp 0", b32.out_valid); end
        checks++; if (b32.in_ready !== 2'b10) begin errors++; $display("FAIL flush_rr_kept: got %b exp 10", b32.in_ready); end
        b32.in_valid = '0;
        step();
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL flush_stage1: got %b exp 0", b32.out_valid); end
        step();
    endtask

    task automatic test_reset_mid();
        b32.out_ready = 1'b1;
        put32(0, 32'h70, LW, 1'b1, 1'b0, 5'd6);
        step();
        put32(0, 32'h80, LW, 1'b1, 1'b0, 5'd7);
        step();
        checks++; if ({b32.out_valid, b32.out_tag} !== {1'b1, 5'd6}) begin
            errors++; $display("FAIL rstmid_before: got v=%b tag=%0d exp v=1 tag=6", b32.out_valid, b32.out_tag); end
        reset = 1'b0;
        flush = 1'b1;
        b32.in_valid = 2'b11;
        settle();
        checks++; if (b32.in_ready !== 2'b00) begin errors++; $display("FAIL rstmid_ready: got %b exp 00", b32.in_ready); end
        step();
        checks++; if ({b32.out_valid, b32.out_addr, b32.out_be, b32.out_tag, b32.out_size, b32.out_wr, b32.out_misaligned} !== 46'h0) begin
            errors++; $display("FAIL rstmid_outputs: got v=%b addr=%h be=%h tag=%0d size=%0d wr=%b mis=%b exp all 0",
                               b32.out_valid, b32.out_addr, b32.out_be, b32.out_tag, b32.out_size, b32.out_wr, b32.out_misaligned); end
        reset = 1'b1;
        flush = 1'b0;
        settle();
        checks++; if (b32.in_ready !== 2'b01) begin errors++; $display("FAIL rstmid_grant0: got %b exp 01", b32.in_ready); end
        b32.in_valid = '0;
        step();
        checks++; if (b32.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dropped: got %b exp 0", b32.out_valid); end
        step();
    endtask

    task automatic test_xlen64();
        b64.out_ready = 1'b1;
        b64.in_valid[0] = 1'b1;
        b64.in_op1[63:0] = 64'hFFFF_FFFF_FFFF_FFFC;
        b64.in_inst[31:0] = LD;
        b64.in_rd[0] = 1'b1;
        b64.in_tag[4:0] = 5'd1;
        settle();
        checks++; if (b64.in_ready !== 2'b01) begin errors++; $display("FAIL x64_ready: got %b exp 01", b64.in_ready); end
        step();
        b64.in_op1[63:0] = 64'hFFFF_FFFF_FFFF_FFF8;
        b64.in_tag[4:0] = 5'd2;
        step();
        b64.in_valid = '0;
        checks++; if ({b64.out_valid, b64.out_addr, b64.out_be, b64.out_misaligned, b64.out_size} !== {1'b1, 64'h4, 8'h00, 1'b1, 2'd3}) begin
            errors++; $display("FAIL x64_wrap_misaligned: got v=%b addr=%h be=%h mis=%b size=%0d exp v=1 addr=0000000000000004 be=00 mis=1 size=3",
                               b64.out_valid, b64.out_addr, b64.out_be, b64.out_misaligned, b64.out_size); end
        step();
        checks++; if ({b64.out_valid, b64.out_addr, b64.out_be, b64.out_misaligned, b64.out_tag} !== {1'b1, 64'h0, 8'hFF, 1'b0, 5'd2}) begin
            errors++; $display("FAIL x64_wrap_aligned: got v=%b addr=%h be=%h mis=%b tag=%0d exp v=1 addr=0000000000000000 be=ff mis=0 tag=2",
                               b64.out_valid, b64.out_addr, b64.out_be, b64.out_misaligned, b64.out_tag); end
        step();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_discard();
        test_arbitration();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_xlen64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
